// File: rtl/lavatory_arbiter_if.sv
// rtl/lavatory_arbiter_if.sv - request, door sensor, grant and status bundle for the lavatory arbiter
interface lavatory_arbiter_if;
    logic       req_f;
    logic       req_m;
    logic [2:0] lock;
    logic       grant_valid;
    logic [1:0] grant_lav;
    logic       grant_fem;
    logic [2:0] qcount_f;
    logic [2:0] qcount_m;
    logic       qfull_f;
    logic       qfull_m;
    logic       led_f;
    logic       led_m;

    modport master (
        output req_f, req_m, lock,
        input  grant_valid, grant_lav, grant_fem,
        input  qcount_f, qcount_m, qfull_f, qfull_m, led_f, led_m
    );

    modport slave (
        input  req_f, req_m, lock,
        output grant_valid, grant_lav, grant_fem,
        output qcount_f, qcount_m, qfull_f, qfull_m, led_f, led_m
    );
endinterface

// File: rtl/lavatory_arbiter.sv
// rtl/lavatory_arbiter.sv - assigns three lavatories to female/male queues with reservation timeout
module lavatory_arbiter #(
    parameter int RESV_CYCLES = 8,
    parameter int QMAX        = 7
) (
    input  logic               clk_2,
    input  logic               reset,
    lavatory_arbiter_if.slave  bus
);

    localparam int         TW         = (RESV_CYCLES > 1) ? $clog2(RESV_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(RESV_CYCLES - 1);
    localparam logic [2:0] QMAX_C     = 3'(QMAX);

    typedef enum logic [1:0] {
        LAV_FREE,
        LAV_RESERVED,
        LAV_OCCUPIED
    } lav_state_t;

    lav_state_t    state [3];
    logic [TW-1:0] timer [3];
    logic [2:0]    cnt_f;
    logic [2:0]    cnt_m;
    logic          rr_male;
    logic          gv_q;
    logic [1:0]    lav_q;
    logic          fem_q;

    logic [2:0]    grantable;
    logic          do_grant;
    logic [1:0]    g_lav;
    logic          g_fem;
    logic          grant_f;
    logic          grant_m;

    // Lavatory 0 is women-only and always wins for the female queue; shared
    // lavatories go lowest index first, queue chosen by round-robin on contention.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            grantable[i] = (state[i] == LAV_FREE) && !bus.lock[i];
        end
        do_grant = 1'b0;
        g_lav    = 2'd0;
        g_fem    = 1'b0;
        if (grantable[0] && (cnt_f != 3'd0)) begin
            do_grant = 1'b1;
            g_lav    = 2'd0;
            g_fem    = 1'b1;
        end else if ((grantable[1] || grantable[2]) && ((cnt_f != 3'd0) || (cnt_m != 3'd0))) begin
            do_grant = 1'b1;
            g_lav    = grantable[1] ? 2'd1 : 2'd2;
            if ((cnt_f != 3'd0) && (cnt_m != 3'd0)) begin
                g_fem = !rr_male;
            end else begin
                g_fem = (cnt_f != 3'd0);
            end
        end
    end

    assign grant_f = do_grant && g_fem;
    assign grant_m = do_grant && !g_fem;

    // A grant cancels a same-cycle request; a lone request at QMAX is dropped.
    function automatic logic [2:0] next_cnt(input logic [2:0] cnt, input logic req, input logic grant);
        if (req && !grant) begin
            return (cnt == QMAX_C) ? cnt : cnt + 3'd1;
        end else if (!req && grant) begin
            return cnt - 3'd1;
        end else begin
            return cnt;
        end
    endfunction

    always_ff @(posedge clk_2) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                state[i] <= LAV_FREE;
                timer[i] <= '0;
            end
            cnt_f   <= 3'd0;
            cnt_m   <= 3'd0;
            rr_male <= 1'b0;
            gv_q    <= 1'b0;
            lav_q   <= 2'd0;
            fem_q   <= 1'b0;
        end else begin
            cnt_f <= next_cnt(cnt_f, bus.req_f, grant_f);
            cnt_m <= next_cnt(cnt_m, bus.req_m, grant_m);
            gv_q  <= do_grant;
            lav_q <= do_grant ? g_lav : 2'd0;
            fem_q <= grant_f;
            if (do_grant && (g_lav != 2'd0)) begin
                rr_male <= !rr_male;
            end
            for (int i = 0; i < 3; i++) begin
                case (state[i])
                    LAV_FREE: begin
                        if (do_grant && (g_lav == 2'(i))) begin
                            state[i] <= LAV_RESERVED;
                            timer[i] <= TIMER_LOAD;
                        end else if (bus.lock[i]) begin
                            state[i] <= LAV_OCCUPIED;
                        end
                    end
                    LAV_RESERVED: begin
                        if (bus.lock[i]) begin
                            state[i] <= LAV_OCCUPIED;
                            timer[i] <= '0;
                        end else if (timer[i] == '0) begin
                            state[i] <= LAV_FREE;
                        end else begin
                            timer[i] <= timer[i] - TW'(1);
                        end
                    end
                    LAV_OCCUPIED: begin
                        if (!bus.lock[i]) begin
                            state[i] <= LAV_FREE;
                        end
                    end
                    default: begin
                        state[i] <= LAV_FREE;
                        timer[i] <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.grant_valid = gv_q;
    assign bus.grant_lav   = lav_q;
    assign bus.grant_fem   = fem_q;
    assign bus.qcount_f    = cnt_f;
    assign bus.qcount_m    = cnt_m;
    assign bus.qfull_f     = (cnt_f == QMAX_C);
    assign bus.qfull_m     = (cnt_m == QMAX_C);
    assign bus.led_f       = (state[0] == LAV_FREE) || (state[1] == LAV_FREE) || (state[2] == LAV_FREE);
    assign bus.led_m       = (state[1] == LAV_FREE) || (state[2] == LAV_FREE);

endmodule

// File: tb/tb_lavatory_arbiter.sv
// tb/tb_lavatory_arbiter.sv - table and sequence driven scoreboard bench for lavatory_arbiter
module tb_lavatory_arbiter;

    logic clk_2;
    logic reset;

    lavatory_arbiter_if bus ();

    lavatory_arbiter #(.RESV_CYCLES(8), .QMAX(7)) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    typedef struct {
        logic       rst;
        logic       rf;
        logic       rm;
        logic [2:0] lk;
        logic       gv;
        logic [1:0] lav;
        logic       fem;
        logic [2:0] qf;
        logic [2:0] qm;
        logic       lf;
        logic       lm;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input int rst, input int rf, input int rm, input int lk,
                                input int gv, input int lav, input int fem,
                                input int qf, input int qm, input int lf, input int lm);
        vec_t v;
        v.rst = rst[0]; v.rf = rf[0]; v.rm = rm[0]; v.lk = 3'(lk);
        v.gv = gv[0]; v.lav = 2'(lav); v.fem = fem[0];
        v.qf = 3'(qf); v.qm = 3'(qm); v.lf = lf[0]; v.lm = lm[0];
        return v;
    endfunction

    task automatic cmp(input string tag, input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s %s got=%0d want=%0d", tag, name, got, want);
        end
    endtask

    task automatic check(input string tag);
        vec_t e;
        e = exp_q.pop_front();
        cmp(tag, "grant_valid", int'(bus.grant_valid), int'(e.gv));
        if (e.gv || e.rst) begin
            cmp(tag, "grant_lav", int'(bus.grant_lav), int'(e.lav));
            cmp(tag, "grant_fem", int'(bus.grant_fem), int'(e.fem));
        end
        cmp(tag, "qcount_f", int'(bus.qcount_f), int'(e.qf));
        cmp(tag, "qcount_m", int'(bus.qcount_m), int'(e.qm));
        cmp(tag, "qfull_f", int'(bus.qfull_f), (e.qf == 3'd7) ? 1 : 0);
        cmp(tag, "qfull_m", int'(bus.qfull_m), (e.qm == 3'd7) ? 1 : 0);
        cmp(tag, "led_f", int'(bus.led_f), int'(e.lf));
        cmp(tag, "led_m", int'(bus.led_m), int'(e.lm));
    endtask

    task automatic step(input vec_t v, input string tag);
        reset     = v.rst;
        bus.req_f = v.rf;
        bus.req_m = v.rm;
        bus.lock  = v.lk;
        exp_q.push_back(v);
        @(posedge clk_2);
        #1;
        check(tag);
    endtask

    initial begin
        reset     = 1'b1;
        bus.req_f = 1'b0;
        bus.req_m = 1'b0;
        bus.lock  = 3'b000;

        // rst rf rm lock | gv lav fem qf qm led_f led_m
        tbl.push_back(mk(1,0,0,3'b000, 0,0,0, 0,0, 1,1));
        tbl.push_back(mk(0,1,0,3'b000, 0,0,0, 1,0, 1,1));
        tbl.push_back(mk(0,0,0,3'b000, 1,0,1, 0,0, 1,1));
        tbl.push_back(mk(0,0,0,3'b001, 0,0,0, 0,0, 1,1));
        tbl.push_back(mk(0,1,1,3'b111, 0,0,0, 1,1, 0,0));
        tbl.push_back(mk(0,1,1,3'b111, 0,0,0, 2,2, 0,0));
        tbl.push_back(mk(0,0,0,3'b011, 0,0,0, 2,2, 1,1));
        tbl.push_back(mk(0,0,0,3'b011, 1,2,1, 1,2, 0,0));
        tbl.push_back(mk(0,0,0,3'b001, 0,0,0, 1,2, 1,1));
        tbl.push_back(mk(0,0,0,3'b001, 1,1,0, 1,1, 0,0));
        tbl.push_back(mk(0,0,0,3'b111, 0,0,0, 1,1, 0,0));
        tbl.push_back(mk(0,0,0,3'b101, 0,0,0, 1,1, 1,1));
        tbl.push_back(mk(0,0,0,3'b101, 1,1,1, 0,1, 0,0));
        tbl.push_back(mk(0,0,0,3'b111, 0,0,0, 0,1, 0,0));
        tbl.push_back(mk(0,0,0,3'b011, 0,0,0, 0,1, 1,1));
        tbl.push_back(mk(0,0,0,3'b011, 1,2,0, 0,0, 0,0));
        // lavatory 0 priority for women, then shared lavatory to men
        tbl.push_back(mk(1,0,0,3'b000, 0,0,0, 0,0, 1,1));
        tbl.push_back(mk(0,1,1,3'b000, 0,0,0, 1,1, 1,1));
        tbl.push_back(mk(0,0,0,3'b000, 1,0,1, 0,1, 1,1));
        tbl.push_back(mk(0,0,0,3'b000, 1,1,0, 0,0, 1,1));
        // walk-in with empty queues
        tbl.push_back(mk(1,0,0,3'b000, 0,0,0, 0,0, 1,1));
        tbl.push_back(mk(0,0,0,3'b010, 0,0,0, 0,0, 1,1));
        tbl.push_back(mk(0,0,0,3'b110, 0,0,0, 0,0, 1,0));
        // reset overrides a pending grant and an occupied lavatory
        tbl.push_back(mk(1,0,0,3'b000, 0,0,0, 0,0, 1,1));
        tbl.push_back(mk(0,1,0,3'b100, 0,0,0, 1,0, 1,1));
        tbl.push_back(mk(1,1,0,3'b100, 0,0,0, 0,0, 1,1));
        tbl.push_back(mk(0,0,0,3'b100, 0,0,0, 0,0, 1,1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("tbl%0d", i));
        end

        // no-show: reservation expires on the 8th edge after the grant
        step(mk(1,0,0,3'b000, 0,0,0, 0,0, 1,1), "ns_rst");
        step(mk(0,0,1,3'b101, 0,0,0, 0,1, 1,1), "ns_req");
        step(mk(0,0,0,3'b101, 1,1,0, 0,0, 0,0), "ns_grant");
        for (int i = 1; i <= 8; i++) begin
            step(mk(0,0,0,3'b101, 0,0,0, 0,0, (i == 8) ? 1 : 0, (i == 8) ? 1 : 0),
                 $sformatf("ns_wait%0d", i));
        end

        // saturation, then request and grant in the same cycle
        step(mk(1,0,0,3'b000, 0,0,0, 0,0, 1,1), "sat_rst");
        for (int k = 1; k <= 8; k++) begin
            step(mk(0,0,1,3'b111, 0,0,0, 0,(k > 7) ? 7 : k, 0,0), $sformatf("sat_req%0d", k));
        end
        step(mk(0,0,0,3'b101, 0,0,0, 0,7, 1,1), "sat_unlock");
        step(mk(0,0,1,3'b101, 1,1,0, 0,7, 0,0), "sat_grant");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
